// File: rtl/bit_time_decoder_if.sv
// Timing-chain sample bus: raw counter flip-flops in, decoded bit/phase timing out.
// Latency: none (wires only); the decoder registers every output.
// Backpressure: none; tick is a strobe and the consumer must accept every sample.
interface bit_time_decoder_if;
  // Raw timing-chain state, qualified by tick
  logic       tick;
  logic       a;
  logic [6:0] g;
  logic       pa;
  logic       pb;
  logic       pc;
  logic       err_clr;

  // Decoded timing and watchdog flags
  logic       valid;
  logic [4:0] bit_idx;
  logic [2:0] phase_idx;
  logic       word_start;
  logic       word_end;
  logic       phase_step;
  logic       ring_err;
  logic       seq_err;

  // Timing-chain side: drives the counter state, observes the decode
  modport master (
    output tick, a, g, pa, pb, pc, err_clr,
    input  valid, bit_idx, phase_idx, word_start, word_end, phase_step, ring_err, seq_err
  );

  // Decoder side
  modport slave (
    input  tick, a, g, pa, pb, pc, err_clr,
    output valid, bit_idx, phase_idx, word_start, word_end, phase_step, ring_err, seq_err
  );
endinterface

// File: rtl/bit_time_decoder.sv
// Decodes the A/G ring and PA/PB/PC phase counter into bit/phase indices, strobes and sticky errors.
// Latency: one clk from a tick edge to updated outputs; all outputs registered.
// Backpressure: none; every tick edge is consumed as one sample, tick may be held high.
module bit_time_decoder #(
  parameter int BITS_PER_WORD = 28,
  parameter int PHASES        = 6
) (
  input  logic            clk,
  input  logic            reset,
  bit_time_decoder_if.slave bus
);

  localparam logic [4:0] LAST_BIT   = 5'(BITS_PER_WORD - 1);
  localparam logic [2:0] LAST_PHASE = 3'(PHASES - 1);
  localparam int         RING_STATES = BITS_PER_WORD / 2;

  // Johnson-ring image of state s: fills with ones from G1, then drains from G1.
  function automatic logic [6:0] ring_pattern(input logic [3:0] s);
    if (s <= 4'd7) begin
      ring_pattern = 7'((8'd1 << s) - 8'd1);
    end else begin
      ring_pattern = ~7'((8'd1 << (s - 4'd7)) - 8'd1);
    end
  endfunction

  logic       valid_q;
  logic [4:0] bit_q;
  logic [2:0] phase_q;
  logic       word_start_q;
  logic       word_end_q;
  logic       phase_step_q;
  logic       ring_err_q;
  logic       seq_err_q;

  logic       g_ok;
  logic [3:0] ring_s;
  logic       ph_ok;
  logic [2:0] new_phase;
  logic [4:0] new_bit;
  logic [4:0] exp_bit;
  logic [2:0] next_phase;
  logic       at_wrap;
  logic       phase_legal;
  logic       seq_bad;

  // Match G against every legal ring state; no match means a broken ring.
  always_comb begin
    g_ok   = 1'b0;
    ring_s = 4'd0;
    for (int i = 0; i < RING_STATES; i++) begin
      if (bus.g == ring_pattern(4'(i))) begin
        g_ok   = 1'b1;
        ring_s = 4'(i);
      end
    end
  end

  // Phase counter is a 6-state Johnson code; 010 and 101 cannot occur in a healthy chain.
  always_comb begin
    ph_ok     = 1'b1;
    new_phase = 3'd0;
    case ({bus.pa, bus.pb, bus.pc})
      3'b000:  new_phase = 3'd0;
      3'b100:  new_phase = 3'd1;
      3'b110:  new_phase = 3'd2;
      3'b111:  new_phase = 3'd3;
      3'b011:  new_phase = 3'd4;
      3'b001:  new_phase = 3'd5;
      default: ph_ok     = 1'b0;
    endcase
  end

  // Compare the new sample with the last good one (the output registers double as the reference).
  always_comb begin
    new_bit     = {ring_s, bus.a};
    exp_bit     = (bit_q == LAST_BIT) ? 5'd0 : bit_q + 5'd1;
    next_phase  = (phase_q == LAST_PHASE) ? 3'd0 : phase_q + 3'd1;
    at_wrap     = (bit_q == LAST_BIT) && (new_bit == 5'd0);
    phase_legal = (new_phase == phase_q) || (at_wrap && (new_phase == next_phase));
    seq_bad     = (new_bit != exp_bit) || !phase_legal;
  end

  // Sample on tick: illegal codes only raise ring_err; legal codes always load so the decoder resyncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      bit_q        <= 5'd0;
      phase_q      <= 3'd0;
      word_start_q <= 1'b0;
      word_end_q   <= 1'b0;
      phase_step_q <= 1'b0;
      ring_err_q   <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      word_start_q <= 1'b0;
      word_end_q   <= 1'b0;
      phase_step_q <= 1'b0;
      // Clear first so a same-cycle set below takes priority.
      if (bus.err_clr) begin
        ring_err_q <= 1'b0;
        seq_err_q  <= 1'b0;
      end
      if (bus.tick) begin
        if (!(g_ok && ph_ok)) begin
          ring_err_q <= 1'b1;
        end else begin
          valid_q      <= 1'b1;
          bit_q        <= new_bit;
          phase_q      <= new_phase;
          word_start_q <= (new_bit == 5'd0);
          word_end_q   <= (new_bit == LAST_BIT);
          phase_step_q <= valid_q && (new_phase != phase_q);
          if (valid_q && seq_bad) begin
            seq_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.valid      = valid_q;
  assign bus.bit_idx    = bit_q;
  assign bus.phase_idx  = phase_q;
  assign bus.word_start = word_start_q;
  assign bus.word_end   = word_end_q;
  assign bus.phase_step = phase_step_q;
  assign bus.ring_err   = ring_err_q;
  assign bus.seq_err    = seq_err_q;

endmodule

// File: tb/tb_bit_time_decoder.sv
// Directed bench for bit_time_decoder: ramp, illegal codes, sequence errors, clear priority, reset.
// Latency: outputs checked 1 time unit after the sampling edge.
// Backpressure: none; stimulus drives one sample per tick edge.
module tb_bit_time_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bit_time_decoder_if bus ();

  bit_time_decoder #(
    .BITS_PER_WORD(28),
    .PHASES(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {valid, bit_idx, phase_idx, word_start, word_end, phase_step, ring_err, seq_err}
  function automatic logic [13:0] obs();
    return {bus.valid, bus.bit_idx, bus.phase_idx, bus.word_start, bus.word_end,
            bus.phase_step, bus.ring_err, bus.seq_err};
  endfunction

  function automatic logic [13:0] mk(input int v, input int b, input int ph, input int ws,
                                     input int we, input int ps, input int re, input int se);
    return {1'(v), 5'(b), 3'(ph), 1'(ws), 1'(we), 1'(ps), 1'(re), 1'(se)};
  endfunction

  // Bench-side Johnson ring encoding for ring state s (g[0] = G1).
  function automatic logic [6:0] gpat(input int s);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 7; i++) begin
      if (s <= 7) p[i] = (i < s);
      else        p[i] = (i >= s - 7);
    end
    return p;
  endfunction

  function automatic logic [2:0] phcode(input int ph);
    case (ph)
      0: return 3'b000;
      1: return 3'b100;
      2: return 3'b110;
      3: return 3'b111;
      4: return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  task automatic set_inputs(input logic [6:0] gv, input logic av, input logic [2:0] pcode);
    bus.g  = gv;
    bus.a  = av;
    {bus.pa, bus.pb, bus.pc} = pcode;
  endtask

  task automatic sample_raw(input logic [6:0] gv, input logic av, input logic [2:0] pcode,
                            input logic clr);
    @(negedge clk);
    set_inputs(gv, av, pcode);
    bus.tick    = 1'b1;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
    bus.tick    = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic sample(input int b, input int ph, input logic clr);
    sample_raw(gpat(b / 2), 1'(b % 2), phcode(ph), clr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
  endtask

  // Reset optionally with a legal tick in the same cycle; reset must win.
  task automatic do_reset(input logic with_tick);
    @(negedge clk);
    reset = 1'b1;
    set_inputs(gpat(2), 1'b1, phcode(1));
    bus.tick = with_tick;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    do_reset(1'b1);
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_ramp();
    logic [13:0] exp;
    for (int k = 1; k <= 56; k++) begin
      int b;
      int ph;
      b  = (k - 1) % 28;
      ph = (k <= 28) ? 0 : 1;
      sample(b, ph, 1'b0);
      exp = mk(1, b, ph, b == 0, b == 27, k == 29, 0, 0);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL ramp_sample_%0d: got %b want %b", k, obs(), exp);
      end
    end
    // Idle cycle: outputs hold, strobes drop
    @(posedge clk);
    #1;
    exp = mk(1, 27, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL ramp_hold: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_illegal_ring();
    logic [13:0] exp;
    sample_raw(7'b0100000, 1'b0, phcode(1), 1'b0);
    exp = mk(1, 27, 1, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL illegal_ring: got %b want %b", obs(), exp);
    end
    sample(0, 1, 1'b0);
    exp = mk(1, 0, 1, 1, 0, 0, 1, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL illegal_ring_recover: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_skipped_bit();
    logic [13:0] exp;
    pulse_clr();
    exp = mk(1, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL skip_clear: got %b want %b", obs(), exp);
    end
    for (int b = 1; b <= 5; b++) sample(b, 1, 1'b0);
    exp = mk(1, 5, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL skip_lead_in: got %b want %b", obs(), exp);
    end
    sample(7, 1, 1'b0);
    exp = mk(1, 7, 1, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL skip_5_to_7: got %b want %b", obs(), exp);
    end
    pulse_clr();
    sample(8, 1, 1'b0);
    exp = mk(1, 8, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL skip_then_8: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_phase_midword();
    logic [13:0] exp;
    do_reset(1'b0);
    sample(10, 2, 1'b0);
    exp = mk(1, 10, 2, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL phase_first_sample: got %b want %b", obs(), exp);
    end
    sample(11, 3, 1'b0);
    exp = mk(1, 11, 3, 0, 0, 1, 0, 1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL phase_midword_step: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_clear_vs_set();
    logic [13:0] exp;
    pulse_clr();
    exp = mk(1, 11, 3, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL clear_plain: got %b want %b", obs(), exp);
    end
    // Illegal phase 101 with err_clr: ring_err set wins, outputs hold
    sample_raw(gpat(6), 1'b0, 3'b101, 1'b1);
    exp = mk(1, 11, 3, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL clear_vs_ring_set: got %b want %b", obs(), exp);
    end
    // Skip 11 -> 14 with err_clr: ring_err cleared, seq_err set wins
    sample(14, 3, 1'b1);
    exp = mk(1, 14, 3, 0, 0, 0, 0, 1);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL clear_vs_seq_set: got %b want %b", obs(), exp);
    end
  endtask

  task automatic test_reset_midword();
    logic [13:0] exp;
    do_reset(1'b1);
    exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL midword_reset_state: got %b want %b", obs(), exp);
    end
    sample(20, 3, 1'b0);
    exp = mk(1, 20, 3, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== exp) begin
      errors++;
      $display("FAIL midword_first_sample: got %b want %b", obs(), exp);
    end
  endtask

  // Tick held high across the word and phase wrap (5 -> 0)
  task automatic test_back_to_back();
    logic [13:0] exp;
    int bits[4]  = '{26, 27, 0, 1};
    int phs[4]   = '{5, 5, 0, 0};
    do_reset(1'b0);
    @(negedge clk);
    bus.tick = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_inputs(gpat(bits[i] / 2), 1'(bits[i] % 2), phcode(phs[i]));
      @(posedge clk);
      #1;
      exp = mk(1, bits[i], phs[i], bits[i] == 0, bits[i] == 27, i == 2, 0, 0);
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL back_to_back_%0d: got %b want %b", i, obs(), exp);
      end
    end
    bus.tick = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.err_clr = 1'b0;
    set_inputs(7'd0, 1'b0, 3'b000);
    repeat (3) @(posedge clk);
    test_reset();
    test_ramp();
    test_illegal_ring();
    test_skipped_bit();
    test_phase_midword();
    test_clear_vs_set();
    test_reset_midword();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
